// File: rtl/alu_sweep_ctrl.sv
// alu_sweep_ctrl: steps a combinational ALU through the masked opcodes of one
// operand pair in ascending order, waits SETTLE cycles per opcode, and returns
// each captured result on a valid/ready stream tagged with its opcode.
module alu_sweep_ctrl #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_mask,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_c,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_op,
  output logic [WIDTH-1:0] res_data,
  output logic             res_last,
  output logic [15:0]      sweep_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE_WAIT, RESP} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]       alu_c_q, alu_c_d;
  logic             res_valid_q, res_valid_d;
  logic [1:0]       res_op_q, res_op_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_last_q, res_last_d;
  logic [15:0]      sweep_cnt_q, sweep_cnt_d;
  logic             cmd_ready_q, cmd_ready_d;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [1:0] low_idx(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) r = 2'(i);
    return r;
  endfunction

  // Mask bits strictly above opcode c: the opcodes still to be issued.
  function automatic logic [3:0] bits_above(input logic [3:0] m, input logic [1:0] c);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 4; i++)
      if (i > int'(c)) r[i] = m[i];
    return r;
  endfunction

  // Next-state and output decode for the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_c_d     = alu_c_q;
    res_valid_d = res_valid_q;
    res_op_d    = res_op_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    sweep_cnt_d = sweep_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          alu_a_d = cmd_a;
          alu_b_d = cmd_b;
          mask_d  = cmd_mask;
          if (cmd_mask != 4'd0) begin
            alu_c_d = low_idx(cmd_mask);
            cnt_d   = SETTLE_C;
            state_d = SETTLE_WAIT;
          end else begin
            // Empty sweep completes immediately with nothing to return.
            sweep_cnt_d = sweep_cnt_q + 16'd1;
          end
        end
      end
      SETTLE_WAIT: begin
        if (cnt_q <= 4'd1) begin
          res_data_d  = alu_out;
          res_op_d    = alu_c_q;
          res_valid_d = 1'b1;
          res_last_d  = (bits_above(mask_q, alu_c_q) == 4'd0);
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          if (res_last_q) begin
            sweep_cnt_d = sweep_cnt_q + 16'd1;
            state_d     = IDLE;
          end else begin
            alu_c_d = low_idx(bits_above(mask_q, alu_c_q));
            cnt_d   = SETTLE_C;
            state_d = SETTLE_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready: only asserted once the FSM is back in IDLE, so a
    // command can never be taken on the same edge as the final handshake.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mask_q      <= 4'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_c_q     <= 2'd0;
      res_valid_q <= 1'b0;
      res_op_q    <= 2'd0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      sweep_cnt_q <= 16'd0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_c_q     <= alu_c_d;
      res_valid_q <= res_valid_d;
      res_op_q    <= res_op_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      sweep_cnt_q <= sweep_cnt_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;
  assign res_valid = res_valid_q;
  assign res_op    = res_op_q;
  assign res_data  = res_data_q;
  assign res_last  = res_last_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for alu_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3), each fed
// by its own ALU model and checked against an opcode-list reference.
module tb_alu_sweep_ctrl;
  localparam int W  = 32;
  localparam int NI = 2;

  logic        gclk;
  logic        rst_n;
  logic        cmd_valid [NI];
  logic        cmd_ready [NI];
  logic [W-1:0] cmd_a    [NI];
  logic [W-1:0] cmd_b    [NI];
  logic [3:0]  cmd_mask  [NI];
  logic [W-1:0] alu_a    [NI];
  logic [W-1:0] alu_b    [NI];
  logic [1:0]  alu_c     [NI];
  logic [W-1:0] alu_out  [NI];
  logic        res_valid [NI];
  logic        res_ready [NI];
  logic [1:0]  res_op    [NI];
  logic [W-1:0] res_data [NI];
  logic        res_last  [NI];
  logic [15:0] sweep_cnt [NI];

  logic [15:0] sc [NI];
  int checks = 0;
  int errors = 0;
  int cur_d  = 0;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, b, input logic [1:0] c);
    case (c)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    alu_sweep_ctrl #(.WIDTH(W), .SETTLE((g == 0) ? 1 : 3)) u_dut (
      .clk(gclk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_a(cmd_a[g]), .cmd_b(cmd_b[g]), .cmd_mask(cmd_mask[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_c(alu_c[g]), .alu_out(alu_out[g]),
      .res_valid(res_valid[g]), .res_ready(res_ready[g]), .res_op(res_op[g]),
      .res_data(res_data[g]), .res_last(res_last[g]), .sweep_cnt(sweep_cnt[g])
    );
    assign alu_out[g] = alu_f(alu_a[g], alu_b[g], alu_c[g]);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL [settle=%0d] %s: got %0h expected %0h", settle_of(cur_d), tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge gclk);
    @(negedge gclk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) sc[i] = 16'd0;
  endtask

  // mode 0: res_ready high, 1: 5-cycle stall per result, 2: random ready.
  task automatic do_cmd(input int d, input logic [W-1:0] a, b, input logic [3:0] m,
                        input int mode, input bit hold);
    int cyc, hi;
    bit seen, bad_rdy;
    logic [W-1:0] ed;
    logic r;
    cmd_valid[d] = 1'b1; cmd_a[d] = a; cmd_b[d] = b; cmd_mask[d] = m;
    res_ready[d] = (mode == 0);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      seen = cmd_ready[d];
      tick();
    end
    chk("accept", 64'(seen), 64'd1);
    if (!seen) return;
    if (!hold) cmd_valid[d] = 1'b0;
    if (m == 4'd0) begin
      sc[d]++;
      chk("m0_ready", 64'(cmd_ready[d]), 64'd1);
      chk("m0_noresult", 64'(res_valid[d]), 64'd0);
      chk("m0_sweep_cnt", 64'(sweep_cnt[d]), 64'(sc[d]));
      return;
    end
    hi = 0;
    for (int k = 0; k < 4; k++) if (m[k]) hi = k;
    bad_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!m[k]) continue;
      ed  = alu_f(a, b, 2'(k));
      cyc = 1;
      while (!res_valid[d] && cyc < 64) begin
        if (cmd_ready[d]) bad_rdy = 1'b1;
        tick();
        cyc++;
      end
      chk("latency", 64'(cyc), 64'(settle_of(d) + 1));
      if (!res_valid[d]) return;
      chk("res_op", 64'(res_op[d]), 64'(k));
      chk("res_data", 64'(res_data[d]), 64'(ed));
      chk("res_last", 64'(res_last[d]), 64'(k == hi));
      chk("ready_in_resp", 64'(cmd_ready[d]), 64'd0);
      chk("alu_abc", {alu_a[d], alu_c[d]}, {a, 2'(k)});
      chk("alu_b", 64'(alu_b[d]), 64'(b));
      if (mode == 1) begin
        res_ready[d] = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_hold", {res_valid[d], res_op[d], res_last[d], res_data[d]},
              {1'b1, 2'(k), (k == hi), ed});
        end
        res_ready[d] = 1'b1;
        tick();
      end else if (mode == 2) begin
        for (int s = 0; s < 64; s++) begin
          r = 1'($urandom % 2);
          if (s == 63) r = 1'b1;
          res_ready[d] = r;
          tick();
          if (r) break;
          chk("rnd_hold", {res_valid[d], res_op[d], res_last[d], res_data[d]},
              {1'b1, 2'(k), (k == hi), ed});
        end
      end else begin
        tick();
      end
      chk("vld_drop", 64'(res_valid[d]), 64'd0);
      if (k == hi) begin
        sc[d]++;
        chk("ready_after_last", 64'(cmd_ready[d]), 64'd1);
        chk("sweep_cnt", 64'(sweep_cnt[d]), 64'(sc[d]));
      end
    end
    chk("ready_low_in_sweep", 64'(bad_rdy), 64'd0);
    res_ready[d] = 1'b0;
  endtask

  task automatic run_suite(input int d);
    bit hit;
    cur_d = d;
    do_reset();
    chk("rst_ready", 64'(cmd_ready[d]), 64'd1);
    chk("rst_outs", {res_valid[d], res_last[d], res_op[d], alu_c[d], sweep_cnt[d], res_data[d]}, 64'd0);
    chk("rst_ab", {alu_a[d], alu_b[d]}, 64'd0);
    // Full sweep, then masked sweep under backpressure, empty mask, single op.
    do_cmd(d, 32'd5, 32'd6, 4'b1111, 0, 1'b0);
    do_cmd(d, 32'd8, 32'd0, 4'b0101, 1, 1'b0);
    do_cmd(d, 32'd3, 32'd9, 4'b0000, 0, 1'b0);
    do_cmd(d, 32'd10, 32'd5, 4'b0010, 0, 1'b0);
    // Abort a sweep while opcode 2 waits in RESP.
    cmd_valid[d] = 1'b1; cmd_a[d] = 32'd10; cmd_b[d] = 32'd5; cmd_mask[d] = 4'b1111;
    res_ready[d] = 1'b1;
    hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      if (res_valid[d] && res_op[d] == 2'd2) hit = 1'b1;
      else begin
        if (!cmd_ready[d]) cmd_valid[d] = 1'b0;
        tick();
      end
    end
    res_ready[d] = 1'b0;
    cmd_valid[d] = 1'b0;
    tick(); tick();
    chk("pre_rst_resp", {res_valid[d], res_op[d]}, {1'b1, 2'd2});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {res_valid[d], res_last[d], res_op[d], alu_c[d], sweep_cnt[d], res_data[d]}, 64'd0);
    chk("async_rst_ab", {alu_a[d], alu_b[d]}, 64'd0);
    chk("async_rst_ready", 64'(cmd_ready[d]), 64'd1);
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) sc[i] = 16'd0;
    repeat (3) tick();
    chk("post_rst", {cmd_ready[d], res_valid[d], sweep_cnt[d]}, {1'b1, 1'b0, 16'd0});
    do_cmd(d, 32'd10, 32'd5, 4'b1111, 0, 1'b0);
    // Back-to-back random commands with cmd_valid held high.
    do_reset();
    for (int n = 0; n < 3; n++)
      do_cmd(d, $urandom, $urandom, 4'($urandom_range(1, 15)), 2, n != 2);
    chk("b2b_sweep_cnt", 64'(sweep_cnt[d]), 64'd3);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      cmd_valid[i] = 1'b0; cmd_a[i] = '0; cmd_b[i] = '0; cmd_mask[i] = '0;
      res_ready[i] = 1'b0; sc[i] = 16'd0;
    end
    for (int d = 0; d < NI; d++) run_suite(d);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_sweep_ctrl.md
Name: alu_sweep_ctrl

Overview:
Sequential driver and collector that sits on the operand/opcode side of the combinational 32-bit ALU (ports a, b, c[1:0], out). It accepts an operand pair on a valid/ready command interface and issues the selected opcodes 00..11 to the ALU in ascending order. After a settle interval it captures each ALU result and returns it on a valid/ready result stream tagged with its opcode. This replaces hand-written #10 stimulus with a reusable, cycle-accurate sequencer for system-level bring-up.

Parameters:
WIDTH, 32, operand/result width
SETTLE, 1, cycles alu_a/alu_b/alu_c are held stable before alu_out is sampled (legal range 1..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept command
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
cmd_mask  input  4  bit k set = issue opcode k
alu_a  output  WIDTH  to ALU a
alu_b  output  WIDTH  to ALU b
alu_c  output  2  to ALU c (opcode)
alu_out  input  WIDTH  from ALU out (combinational)
res_valid  output  1  result present
res_ready  input  1  consumer accepts result
res_op  output  2  opcode of this result
res_data  output  WIDTH  captured ALU result
res_last  output  1  final result of current command
sweep_cnt  output  16  commands fully completed, wraps at 0xFFFF->0

Behaviour:
- All outputs registered. Reset (async on rst_n low, release synchronous to clk): state IDLE, cmd_ready=1, res_valid=0, res_last=0, res_op=0, res_data=0, alu_a=0, alu_b=0, alu_c=0, sweep_cnt=0.
- States: IDLE, SETTLE_WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_a/cmd_b into alu_a/alu_b and latch the mask.
  - Mask nonzero: alu_c = lowest set bit index; settle counter=SETTLE; go SETTLE_WAIT; cmd_ready=0 next cycle.
  - Mask 0: no results; sweep_cnt+1; stay IDLE.
- SETTLE_WAIT: decrement counter each cycle. When it reaches 1, sample alu_out into res_data, alu_c into res_op, set res_valid=1, and set res_last=1 iff no higher mask bit remains; go RESP.
  - With SETTLE=1, res_valid asserts 2 cycles after command acceptance: accept edge, then one settle edge.
- RESP: hold res_valid, res_data, res_op, res_last and alu_* stable until res_valid&res_ready.
  - On that edge, if res_last: res_valid=0, sweep_cnt+1, go IDLE with cmd_ready=1.
  - Otherwise: res_valid=0, alu_c = next higher set mask bit, reload counter, go SETTLE_WAIT.
- res_valid never drops without a handshake. cmd_ready=0 in every state other than IDLE.
- No command is accepted in the same cycle as a res_last handshake; the earliest next acceptance is the following cycle.
- alu_a/alu_b are constant for the whole sweep. alu_c changes only on state-transition edges, never while res_valid=1.
- Results are never reordered. Opcodes are strictly ascending within a sweep.
- rst_n low mid-sweep: immediate abort, all outputs to reset values, no partial result delivered after release.
- res_ready held high: back-to-back ops are spaced SETTLE+1 cycles apart.
- WIDTH arithmetic is irrelevant here; the block passes alu_out through unmodified.

Test Plan:
- Bench ALU model: 00 a+b, 01 a-b, 10 a&b, 11 a|b (32-bit, wrapping).
- Full sweep: A=5, B=6, mask=1111, res_ready=1 -> results (0,11), (1,0xFFFFFFFF), (2,4), (3,7); res_last only on op 3; sweep_cnt=1.
- Partial mask with backpressure: A=8, B=0, mask=0101, res_ready low for 5 cycles per result -> (0,8) then (2,0). Data and op stay stable while stalled, res_last set on op 2 only. Also issue mask=0000 -> no results, sweep_cnt increments.
- Settle/latency: SETTLE=3, A=10, B=5, mask=0010 -> res_valid exactly 4 cycles after accept, (1,5), res_last=1. Confirm cmd_ready=0 throughout and returns to 1 the cycle after the handshake.
- Reset mid-sweep: start A=10, B=5, mask=1111; pull rst_n low while op 2 is in RESP -> all outputs 0 asynchronously. After release, cmd_ready=1, no stale res_valid, sweep_cnt=0. A new command then completes normally.
- Back-to-back commands: 3 commands, cmd_valid held high, res_ready random 50% -> every result is correct per the model and in order, no command lost or duplicated, sweep_cnt=3.
